sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
Single-clock FIFO with parametrised width and depth, fill level, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. The read port runs in one of two modes: first-word-fall-through (FWFT) or registered standard mode. It is the same-clock companion to the dual-clock FIFO and is used wherever producer and consumer share one clock domain.

Parameters:
- WIDTH, 8, data width in bits.
- POINTER, 4, address width; DEPTH = 2^POINTER entries.
- AFULL_LEVEL, 14, wr_afull asserts when level >= AFULL_LEVEL; legal range 1..DEPTH.
- AEMPTY_LEVEL, 2, rd_aempty asserts when level <= AEMPTY_LEVEL; legal range 0..DEPTH-1.
- FWFT, 1, 1 = head word visible on data_out while not empty; 0 = registered read, data one cycle after rden.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- areset  in  1  asynchronous active-high reset.
- flush  in  1  synchronous clear of pointers, level and error flags; memory contents untouched.
- wren  in  1  write request.
- data_in  in  WIDTH  write data.
- wr_full  out  1  level == DEPTH.
- wr_afull  out  1  almost full.
- rden  in  1  read request; in FWFT mode, acknowledges and pops the head word.
- data_out  out  WIDTH  read data.
- rd_valid  out  1  FWFT: equals !rd_empty. Standard: 1-cycle pulse, data_out valid.
- rd_empty  out  1  level == 0.
- rd_aempty  out  1  almost empty.
- level  out  POINTER+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set by wren while wr_full.
- underflow  out  1  sticky; set by rden while rd_empty.

Behaviour:
- Reset (areset=1, immediate): wr_ptr=rd_ptr=0, level=0, rd_empty=1, rd_aempty=1, wr_full=0, wr_afull=0, overflow=0, underflow=0, rd_valid=0.
- Reset value of data_out: 0 in standard mode; undefined memory read in FWFT mode (the bench must not check it while rd_empty).
- Pointers: POINTER+1 bits, binary. Address = low POINTER bits. Wrap is natural modulo 2^(POINTER+1).
- Full/empty decode:
  - full = MSBs differ and low bits are equal.
  - empty = pointers are equal.
  - level = wr_ptr - rd_ptr, computed modulo 2^(POINTER+1).
- Write accept: wr_acc = wren & !wr_full. Memory is written at mem[wr_ptr] and wr_ptr increments on the same edge.
- Read accept: rd_acc = rden & !rd_empty. rd_ptr increments on the accepting edge.
- Flags (full, empty, afull, aempty, level) are all registered or derived from registered pointers. They reflect accepted operations on the cycle after the edge, so there is no combinational path from wren/rden to the flags.
- Simultaneous write and read:
  - Neither full nor empty: both accepted, level unchanged.
  - Empty: write only accepted; the read is rejected and sets underflow.
  - Full: read only accepted; the write is rejected and sets overflow.
- No bypass: a word written into an empty FIFO is readable no earlier than the next cycle in either mode.
- FWFT=1: data_out = mem[rd_ptr[POINTER-1:0]] whenever !rd_empty. Popping presents the next word on the following cycle. Zero-latency read.
- FWFT=0: on rd_acc, data_out <= mem[rd_ptr] and rd_valid=1 on the next cycle; otherwise rd_valid=0 and data_out holds its value. Latency is 1 cycle.
- overflow/underflow: set on the rejected request. Cleared only by areset or flush.
- flush:
  - Same effect as reset on pointers, flags and level.
  - Standard mode: rd_valid=0, data_out holds.
  - flush has priority over wren/rden on the same edge; those requests are discarded and do not set error flags.
- areset mid-operation: all state returns to reset values immediately. No partial write is guaranteed.

Decomposition:
- Shared package/header fifo_defs holds:
  - depth function (1<<POINTER);
  - the pointer full/empty/level compare helpers, reused by async_fifo successors;
  - the mode constants FWFT_MODE=1 and STD_MODE=0.
- One sub-module is natural: fifo_ram (WIDTH x DEPTH, one synchronous write port, one read address, combinational read). Registering the read output for standard mode lives in sync_fifo.

Test Plan:
- Reset, then 16 writes 0x00..0x0F, no reads -> level 16, wr_full=1, wr_afull=1 from level 14 onward; a 17th write sets overflow=1 and level stays 16.
- FWFT=1: write 0xA5 into empty FIFO -> rd_empty falls the next cycle with data_out=0xA5; rden pop -> rd_empty=1 the cycle after.
- FWFT=0: write 0x11, 0x22, then rden on two cycles -> rd_valid pulses with 0x11 then 0x22, one cycle after each rden; a third rden sets underflow=1.
- Fill to level 8, then 40 cycles of simultaneous wren/rden with an incrementing pattern -> level stays 8, output order is preserved across pointer wrap, no error flags.
- Full FIFO with wren=rden=1 -> read accepted, write rejected, overflow=1, level 15. Empty FIFO with both asserted -> write accepted, underflow=1, level 1.
- Level 10, then flush=1 together with wren=1 -> next cycle level 0, rd_empty=1, overflow/underflow=0. An areset pulse mid-burst gives the same state immediately.

Source files
------------

// File: rtl/fifo_defs_pkg.sv
// rtl/fifo_defs_pkg.sv - shared FIFO constants and pointer compare helpers
package fifo_defs_pkg;

  localparam int unsigned FWFT_MODE = 1;
  localparam int unsigned STD_MODE  = 0;

  // Number of entries addressed by a POINTER-bit address.
  function automatic int unsigned fifo_depth(input int unsigned pointer);
    return 32'd1 << pointer;
  endfunction

  // Pointers carry one extra wrap bit above the address bits.
  function automatic logic ptr_empty(input int unsigned wp, input int unsigned rp);
    return wp == rp;
  endfunction

  // Full when only the wrap bit differs.
  function automatic logic ptr_full(input int unsigned wp, input int unsigned rp,
                                    input int unsigned pointer);
    return (wp ^ rp) == (32'd1 << pointer);
  endfunction

  // Occupancy, modulo the (pointer+1)-bit pointer range.
  function automatic int unsigned ptr_level(input int unsigned wp, input int unsigned rp,
                                            input int unsigned pointer);
    return (wp - rp) & ((32'd2 << pointer) - 32'd1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - WIDTH x DEPTH storage, synchronous write, combinational read
module sync_fifo_ram
  import fifo_defs_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned POINTER = 4
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [POINTER-1:0] wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [POINTER-1:0] rd_addr,
  output logic [WIDTH-1:0]   rd_data
);

  localparam int unsigned DEPTH = fifo_depth(POINTER);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is never reset or flushed; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with FWFT or registered read port
module sync_fifo
  import fifo_defs_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned POINTER      = 4,
  parameter int unsigned AFULL_LEVEL  = 14,
  parameter int unsigned AEMPTY_LEVEL = 2,
  parameter int unsigned FWFT         = 1
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               flush,
  input  logic               wren,
  input  logic [WIDTH-1:0]   data_in,
  output logic               wr_full,
  output logic               wr_afull,
  input  logic               rden,
  output logic [WIDTH-1:0]   data_out,
  output logic               rd_valid,
  output logic               rd_empty,
  output logic               rd_aempty,
  output logic [POINTER:0]   level,
  output logic               overflow,
  output logic               underflow
);

  localparam int unsigned PW = POINTER + 1;

  logic [POINTER:0] wr_ptr_q, wr_ptr_d;
  logic [POINTER:0] rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             full_w, empty_w;
  logic [POINTER:0] level_w;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] ram_rd_data;

  assign full_w  = ptr_full(32'(wr_ptr_q), 32'(rd_ptr_q), POINTER);
  assign empty_w = ptr_empty(32'(wr_ptr_q), 32'(rd_ptr_q));
  assign level_w = PW'(ptr_level(32'(wr_ptr_q), 32'(rd_ptr_q), POINTER));

  assign wr_acc = wren & ~full_w;
  assign rd_acc = rden & ~empty_w;

  assign wr_full   = full_w;
  assign rd_empty  = empty_w;
  assign level     = level_w;
  assign wr_afull  = 32'(level_w) >= AFULL_LEVEL;
  assign rd_aempty = 32'(level_w) <= AEMPTY_LEVEL;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Next pointers and sticky error flags; flush wins and discards both requests.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
      if (wren && full_w)  overflow_d  = 1'b1;
      if (rden && empty_w) underflow_d = 1'b1;
    end
  end

  // Pointer and error flag registers.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_ram #(
    .WIDTH   (WIDTH),
    .POINTER (POINTER)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc & ~flush),
    .wr_addr (wr_ptr_q[POINTER-1:0]),
    .wr_data (data_in),
    .rd_addr (rd_ptr_q[POINTER-1:0]),
    .rd_data (ram_rd_data)
  );

  if (FWFT == FWFT_MODE) begin : g_fwft
    assign data_out = ram_rd_data;
    assign rd_valid = ~empty_w;
  end else begin : g_std
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             rd_valid_q, rd_valid_d;

    // Capture the head word on an accepted read; data holds otherwise.
    always_comb begin
      data_out_d = data_out_q;
      rd_valid_d = 1'b0;
      if (!flush && rd_acc) begin
        data_out_d = ram_rd_data;
        rd_valid_d = 1'b1;
      end
    end

    // Registered read port.
    always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
        data_out_q <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        data_out_q <= data_out_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench driving an FWFT and a standard-mode sync_fifo
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       flush = 1'b0;
  logic       wren = 1'b0;
  logic       rden = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic       wr_full_f, wr_afull_f, rd_valid_f, rd_empty_f, rd_aempty_f, overflow_f, underflow_f;
  logic [7:0] data_out_f;
  logic [4:0] level_f;
  logic       wr_full_s, wr_afull_s, rd_valid_s, rd_empty_s, rd_aempty_s, overflow_s, underflow_s;
  logic [7:0] data_out_s;
  logic [4:0] level_s;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mq[$];
  logic       movf = 1'b0;
  logic       munf = 1'b0;
  logic       exp_sv = 1'b0;
  logic [7:0] exp_sd = 8'h00;

  always #5 clk = ~clk;

  sync_fifo #(.WIDTH(8), .POINTER(4), .AFULL_LEVEL(14), .AEMPTY_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .areset(areset), .flush(flush), .wren(wren), .data_in(data_in),
    .wr_full(wr_full_f), .wr_afull(wr_afull_f), .rden(rden), .data_out(data_out_f),
    .rd_valid(rd_valid_f), .rd_empty(rd_empty_f), .rd_aempty(rd_aempty_f), .level(level_f),
    .overflow(overflow_f), .underflow(underflow_f)
  );

  sync_fifo #(.WIDTH(8), .POINTER(4), .AFULL_LEVEL(14), .AEMPTY_LEVEL(2), .FWFT(0)) u_std (
    .clk(clk), .areset(areset), .flush(flush), .wren(wren), .data_in(data_in),
    .wr_full(wr_full_s), .wr_afull(wr_afull_s), .rden(rden), .data_out(data_out_s),
    .rd_valid(rd_valid_s), .rd_empty(rd_empty_s), .rd_aempty(rd_aempty_s), .level(level_s),
    .overflow(overflow_s), .underflow(underflow_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    int lvl;
    lvl = mq.size();
    chk("f_level",  32'(level_f),     32'(lvl));
    chk("f_full",   32'(wr_full_f),   32'(lvl == 16));
    chk("f_afull",  32'(wr_afull_f),  32'(lvl >= 14));
    chk("f_empty",  32'(rd_empty_f),  32'(lvl == 0));
    chk("f_aempty", 32'(rd_aempty_f), 32'(lvl <= 2));
    chk("f_valid",  32'(rd_valid_f),  32'(lvl != 0));
    chk("f_ovf",    32'(overflow_f),  32'(movf));
    chk("f_unf",    32'(underflow_f), 32'(munf));
    if (lvl != 0) chk("f_dout", 32'(data_out_f), 32'(mq[0]));
    chk("s_level",  32'(level_s),     32'(lvl));
    chk("s_full",   32'(wr_full_s),   32'(lvl == 16));
    chk("s_afull",  32'(wr_afull_s),  32'(lvl >= 14));
    chk("s_empty",  32'(rd_empty_s),  32'(lvl == 0));
    chk("s_aempty", 32'(rd_aempty_s), 32'(lvl <= 2));
    chk("s_ovf",    32'(overflow_s),  32'(movf));
    chk("s_unf",    32'(underflow_s), 32'(munf));
    chk("s_valid",  32'(rd_valid_s),  32'(exp_sv));
    chk("s_dout",   32'(data_out_s),  32'(exp_sd));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic f);
    logic wacc, racc;
    wren = w; data_in = d; rden = r; flush = f;
    check_state();
    @(posedge clk);
    if (f) begin
      mq.delete();
      movf = 1'b0;
      munf = 1'b0;
      exp_sv = 1'b0;
    end else begin
      wacc = w && (mq.size() < 16);
      racc = r && (mq.size() > 0);
      if (w && !wacc) movf = 1'b1;
      if (r && !racc) munf = 1'b1;
      exp_sv = racc;
      if (racc) exp_sd = mq.pop_front();
      if (wacc) mq.push_back(d);
    end
    @(negedge clk);
    wren = 1'b0; rden = 1'b0; flush = 1'b0;
  endtask

  // Asynchronous reset applied between edges; state must clear immediately.
  task automatic rst_pulse();
    areset = 1'b1;
    #1;
    mq.delete();
    movf = 1'b0; munf = 1'b0; exp_sv = 1'b0; exp_sd = 8'h00;
    check_state();
    wren = 1'b0; rden = 1'b0; flush = 1'b0;
    @(negedge clk);
    areset = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_pulse();

    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h10, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    pat = 8'h80;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, pat, 1'b1, 1'b0);
      pat = pat + 8'd1;
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    wren = 1'b1; data_in = 8'h55;
    rst_pulse();
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
            1'($urandom_range(0, 49) == 0));
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
